instcache_control: RTL and testbench



---
 rtl/instcache_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 25 ++
 rtl/instcache_control.sv | 119 +++++++++++
 tb/tb_instcache_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instcache_ctrl_pkg.sv
// Shared types and constants for the L1 instruction cache control FSM.
package instcache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT1 = 3'd3,
    ST_WAIT2 = 3'd4
  } state_e;

  localparam logic [2:0] WCS_NONE  = 3'b000;
  localparam logic [2:0] WCS_FETCH = 3'b011;
  localparam logic [2:0] WCS_FILL  = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/instcache_control.sv
// Control FSM for the two-way, eight-set instruction cache: lookup, line fetch,
// fill, and hit/miss performance counters.
module instcache_control
  import instcache_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  output logic             mem_resp,
  output logic             pmem_read,
  input  logic             pmem_resp,
  input  logic             HIT,
  input  logic             way_hit,
  input  logic             lru_data,
  input  logic [1:0]       valid_out,
  output logic             LD_LRU_in,
  output logic             lru_in_value,
  output logic [1:0]       LD_VALID,
  output logic             valid_in,
  output logic [1:0]       LD_TAG,
  output logic [2:0]       W_CACHE_STATUS,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_e state_reg, state_next;
  logic   refill_reg, refill_next;
  logic   fill_en;
  logic   hit_inc;
  logic   miss_inc;

  // Victim choice is purely LRU, so the per-way valid bits are not consulted.
  logic unused_valid_out;
  assign unused_valid_out = ^valid_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      refill_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      refill_reg <= refill_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    refill_next    = refill_reg;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    LD_LRU_in      = 1'b0;
    lru_in_value   = 1'b0;
    valid_in       = 1'b0;
    fill_en        = 1'b0;
    W_CACHE_STATUS = WCS_NONE;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (mem_read) begin
          state_next  = ST_CHECK;
          refill_next = 1'b0;
        end
      end
      ST_CHECK: begin
        if (!mem_read) begin
          state_next = ST_IDLE;
        end else if (HIT) begin
          mem_resp     = 1'b1;
          LD_LRU_in    = 1'b1;
          lru_in_value = ~way_hit;
          // The confirming look after a fill is not a genuine hit.
          hit_inc      = ~refill_reg;
          state_next   = ST_IDLE;
        end else begin
          miss_inc    = 1'b1;
          refill_next = 1'b1;
          state_next  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        W_CACHE_STATUS = WCS_FETCH;
        pmem_read      = 1'b1;
        if (pmem_resp) begin
          W_CACHE_STATUS = WCS_FILL;
          fill_en        = 1'b1;
          valid_in       = 1'b1;
          state_next     = ST_WAIT1;
        end
      end
      ST_WAIT1: state_next = ST_WAIT2;
      ST_WAIT2: state_next = ST_CHECK;
      default:  state_next = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_way_load
    assign LD_TAG[gi]   = fill_en & (lru_data == 1'(gi));
    assign LD_VALID[gi] = fill_en & (lru_data == 1'(gi));
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_instcache_control.sv
// Bench for instcache_control: a stand-in datapath plus a set-associative
// reference model that predicts hit/miss, victim way, timing and counters.
module tb_instcache_control;
  import instcache_ctrl_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read;
  logic [31:0]      mem_address;
  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_resp;
  logic             HIT;
  logic             way_hit;
  logic             lru_data;
  logic [1:0]       valid_out;
  logic             LD_LRU_in;
  logic             lru_in_value;
  logic [1:0]       LD_VALID;
  logic             valid_in;
  logic [1:0]       LD_TAG;
  logic [2:0]       W_CACHE_STATUS;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instcache_control #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_resp       (mem_resp),
    .pmem_read      (pmem_read),
    .pmem_resp      (pmem_resp),
    .HIT            (HIT),
    .way_hit        (way_hit),
    .lru_data       (lru_data),
    .valid_out      (valid_out),
    .LD_LRU_in      (LD_LRU_in),
    .lru_in_value   (lru_in_value),
    .LD_VALID       (LD_VALID),
    .valid_in       (valid_in),
    .LD_TAG         (LD_TAG),
    .W_CACHE_STATUS (W_CACHE_STATUS),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // Stand-in datapath: tag/valid/LRU arrays driven by the controller's load strobes.
  logic [23:0] dp_tag [8][2];
  logic        dp_val [8][2];
  logic        dp_lru [8];
  logic [2:0]  dp_idx;
  logic [23:0] dp_tg;
  logic        dp_h0, dp_h1;

  always_comb begin
    dp_idx    = mem_address[7:5];
    dp_tg     = mem_address[31:8];
    dp_h0     = dp_val[dp_idx][0] && (dp_tag[dp_idx][0] == dp_tg);
    dp_h1     = dp_val[dp_idx][1] && (dp_tag[dp_idx][1] == dp_tg);
    HIT       = dp_h0 | dp_h1;
    way_hit   = dp_h1;
    lru_data  = dp_lru[dp_idx];
    valid_out = {dp_val[dp_idx][1], dp_val[dp_idx][0]};
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        dp_val[s][0] <= 1'b0;
        dp_val[s][1] <= 1'b0;
        dp_lru[s]    <= 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (LD_TAG[w])   dp_tag[dp_idx][w] <= dp_tg;
        if (LD_VALID[w]) dp_val[dp_idx][w] <= valid_in;
      end
      if (LD_LRU_in) dp_lru[dp_idx] <= lru_in_value;
    end
  end

  // Reference model of cache contents and expected counter values.
  logic [23:0] ref_tag [8][2];
  bit          ref_val [8][2];
  bit          ref_lru [8];
  int          exp_hits;
  int          exp_misses;

  task automatic ref_reset();
    for (int s = 0; s < 8; s++) begin
      ref_val[s][0] = 1'b0;
      ref_val[s][1] = 1'b0;
      ref_lru[s]    = 1'b0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= int'(CNT_MAX)) ? int'(CNT_MAX) : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
    chk({name, "_miss_count"}, 32'(miss_count), 32'(exp_misses));
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_mem_resp"}, 32'(mem_resp), 32'd0);
    chk({name, "_pmem_read"}, 32'(pmem_read), 32'd0);
    chk({name, "_ld_tag"}, 32'(LD_TAG), 32'd0);
    chk({name, "_ld_valid"}, 32'(LD_VALID), 32'd0);
    chk({name, "_valid_in"}, 32'(valid_in), 32'd0);
    chk({name, "_wcs"}, 32'(W_CACHE_STATUS), 32'd0);
    chk({name, "_ld_lru"}, 32'(LD_LRU_in), 32'd0);
    chk({name, "_lru_val"}, 32'(lru_in_value), 32'd0);
  endtask

  // One CPU fetch. lat: adaptor latency. drop_cyc: cycle (relative to the
  // request at cycle 0) from which mem_read is low, or -1 to hold it.
  task automatic txn(input logic [31:0] addr, input int lat, input int drop_cyc, input string name);
    int          idx;
    logic [23:0] tg;
    bit          hit;
    bit          way;
    bit          fill_way;
    bit          held;
    int          last;
    idx = int'(addr[7:5]);
    tg  = addr[31:8];
    hit = 1'b0;
    way = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (ref_val[idx][w] && ref_tag[idx][w] == tg) begin
        hit = 1'b1;
        way = 1'(w);
      end
    end
    fill_way    = ref_lru[idx];
    held        = (drop_cyc < 0) || (drop_cyc > 5 + lat);
    last        = (drop_cyc == 1 || hit) ? 1 : 5 + lat;
    mem_address = addr;
    for (int c = 0; c <= last; c++) begin
      bit         e_resp, e_pread, e_lru, e_lruv;
      logic [1:0] e_tag;
      logic [2:0] e_wcs;
      e_resp = 0; e_pread = 0; e_lru = 0; e_lruv = 0; e_tag = 2'b00; e_wcs = WCS_NONE;
      mem_read  = (drop_cyc >= 0 && c >= drop_cyc) ? 1'b0 : 1'b1;
      pmem_resp = (!hit && drop_cyc != 1 && c == 2 + lat);
      if (c == 1 && drop_cyc != 1 && hit) begin
        e_resp = 1; e_lru = 1; e_lruv = ~way;
      end
      if (!hit && drop_cyc != 1) begin
        if (c >= 2 && c <= 2 + lat) begin
          e_pread = 1;
          e_wcs   = (c == 2 + lat) ? WCS_FILL : WCS_FETCH;
        end
        if (c == 2 + lat) e_tag = fill_way ? 2'b10 : 2'b01;
        if (c == 5 + lat && held) begin
          e_resp = 1; e_lru = 1; e_lruv = ~fill_way;
        end
      end
      @(negedge clk);
      chk($sformatf("%s_c%0d_mem_resp", name, c), 32'(mem_resp), 32'(e_resp));
      chk($sformatf("%s_c%0d_pmem_read", name, c), 32'(pmem_read), 32'(e_pread));
      chk($sformatf("%s_c%0d_ld_tag", name, c), 32'(LD_TAG), 32'(e_tag));
      chk($sformatf("%s_c%0d_ld_valid", name, c), 32'(LD_VALID), 32'(e_tag));
      chk($sformatf("%s_c%0d_valid_in", name, c), 32'(valid_in), 32'(|e_tag));
      chk($sformatf("%s_c%0d_wcs", name, c), 32'(W_CACHE_STATUS), 32'(e_wcs));
      chk($sformatf("%s_c%0d_ld_lru", name, c), 32'(LD_LRU_in), 32'(e_lru));
      if (e_lru) chk($sformatf("%s_c%0d_lru_val", name, c), 32'(lru_in_value), 32'(e_lruv));
      step();
    end
    mem_read  = 1'b0;
    pmem_resp = 1'b0;
    if (drop_cyc != 1) begin
      if (hit) begin
        exp_hits     = sat_inc(exp_hits);
        ref_lru[idx] = ~way;
      end else begin
        exp_misses              = sat_inc(exp_misses);
        ref_tag[idx][fill_way]  = tg;
        ref_val[idx][fill_way]  = 1'b1;
        if (held) ref_lru[idx] = ~fill_way;
      end
    end
    chk_counters(name);
    $display("txn %-12s addr=%08h lat=%0d drop=%0d %s hits=%0d misses=%0d",
             name, addr, lat, drop_cyc, hit ? "hit" : "miss", hit_count, miss_count);
  endtask

  initial begin
    rst         = 1'b1;
    mem_read    = 1'b0;
    pmem_resp   = 1'b0;
    mem_address = 32'd0;
    ref_reset();
    step();
    step();
    chk_outputs_zero("reset");
    chk_counters("reset");
    rst = 1'b0;
    step();

    txn(32'h0000_0040, 3, -1, "cold_miss");
    txn(32'h0000_0040, 0, -1, "repeat_hit");
    txn(32'h0000_0140, 2, -1, "alt_way1");
    txn(32'h0000_0040, 0, -1, "rehit_way0");
    txn(32'h0000_1040, 1, 1, "drop_check");
    txn(32'h0000_2040, 3, 3, "drop_fetch");
    txn(32'h0000_2040, 0, -1, "after_drop");

    // Reset while a line fetch is outstanding.
    mem_address = 32'h0000_0300;
    mem_read    = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("rstfetch_pre_pmem_read", 32'(pmem_read), 32'd1);
    step();
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("rstfetch_inflight_pmem_read", 32'(pmem_read), 32'd1);
    step();
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    chk_outputs_zero("rstfetch_after");
    chk_counters("rstfetch_after");
    step();
    txn(32'h0000_0300, 1, -1, "post_rst_miss");

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          lat;
      int          r;
      int          drop;
      a    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
             32'($urandom_range(0, 31));
      lat  = int'($urandom_range(0, 4));
      r    = int'($urandom_range(0, 7));
      drop = (r == 0) ? 1 : (r == 1) ? 2 + int'($urandom_range(0, lat)) : -1;
      txn(a, lat, drop, $sformatf("rnd%0d", n));
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_reset();
    step();
    txn(32'h0000_0040, 1, -1, "sat_fill");
    for (int n = 0; n < 20; n++) txn(32'h0000_0040, 0, -1, $sformatf("sat_hit%0d", n));
    chk("sat_hit_count_max", 32'(hit_count), 32'(CNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
